// File: rtl/wait_state_mem.sv
// Single-port data memory with WAIT_CYCLES extra cycles per access, byte-lane writes and address checking.
// A request is latched in IDLE, held in BUSY for WAIT_CYCLES+1 cycles, and completed with a one-cycle ready pulse in DONE.
module wait_state_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    ready,
    output logic                    err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           req_idx;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [BYTES-1:0]        req_be;
    logic                    req_write;
    logic                    req_legal;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   off;
    logic [ADDR_WIDTH-1:0]   index_full;
    logic                    legal;

    // The offset wraps for addresses below BASE, so the explicit compare catches those.
    assign off        = addr - BASE;
    assign index_full = off >> LB;
    assign legal      = (addr >= BASE)
                     && (index_full < ADDR_WIDTH'(DEPTH))
                     && ((off & ADDR_WIDTH'(BYTES - 1)) == '0)
                     && !(mem_read && mem_write);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            read_data <= '0;
            req_idx   <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            req_write <= 1'b0;
            req_legal <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (mem_read || mem_write) begin
                        req_idx   <= index_full[IW-1:0];
                        req_wdata <= write_data;
                        req_be    <= byte_en;
                        req_write <= mem_write;
                        req_legal <= legal;
                        cnt       <= CW'(WAIT_CYCLES);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (req_legal) begin
                            if (req_write) begin
                                for (int b = 0; b < BYTES; b++) begin
                                    if (req_be[b]) begin
                                        mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                                    end
                                end
                            end else begin
                                read_data <= mem[req_idx];
                            end
                        end
                        ready <= 1'b1;
                        err   <= ~req_legal;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so a held request is seen as a fresh access.
                    ready <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wait_state_mem.sv
// Directed bench for wait_state_mem: a WAIT_CYCLES=3 instance for function and timing, a WAIT_CYCLES=0 instance for throughput.
module tb_wait_state_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr = '0, write_data = '0, read_data;
    logic [3:0]  byte_en = '0;
    logic        ready, err;

    logic        r0 = 1'b0, w0 = 1'b0;
    logic [31:0] a0 = '0, wd0 = '0, rd0;
    logic [3:0]  be0 = '0;
    logic        rdy0, err0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {logic e; logic [31:0] d;} exp_t;
    exp_t        sb[$];
    logic [31:0] mdl[64];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    wait_state_mem u (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
        .write_data(write_data), .byte_en(byte_en), .read_data(read_data), .ready(ready), .err(err)
    );

    wait_state_mem #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .mem_read(r0), .mem_write(w0), .addr(a0),
        .write_data(wd0), .byte_en(be0), .read_data(rd0), .ready(rdy0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one access at cycle 0 (just after an edge) and checks latency, err and read_data.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input logic exp_err,
                          input logic change_mid);
        exp_t e;
        exp_t got;
        int   lat;
        e.e = exp_err;
        e.d = last_rd;
        if (!exp_err && rd) begin
            e.d     = mdl[(a - 32'd1024) >> 2];
            last_rd = e.d;
        end
        if (!exp_err && wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mdl[(a - 32'd1024) >> 2][8*i +: 8] = wd[8*i +: 8];
        end
        sb.push_back(e);
        mem_read = rd; mem_write = wr; addr = a; write_data = wd; byte_en = be;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (change_mid && lat == 2) begin
                addr       = a + 32'd4;
                write_data = ~wd;
            end
            if (ready) break;
        end
        check({tag, "_latency"}, lat, 5);
        got = sb.pop_front();
        check({tag, "_err"}, {31'd0, err}, {31'd0, got.e});
        check({tag, "_rdata"}, read_data, got.d);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rdata", read_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        access("rd_word5", 1'b1, 1'b0, 32'd1044, 32'd0, 4'h0, 1'b0, 1'b0);

        access("wr_full", 1'b0, 1'b1, 32'd1024, 32'hAABBCCDD, 4'b1111, 1'b0, 1'b0);
        access("wr_lanes", 1'b0, 1'b1, 32'd1024, 32'h11223344, 4'b0101, 1'b0, 1'b0);
        access("rd_lanes", 1'b1, 1'b0, 32'd1024, 32'd0, 4'h0, 1'b0, 1'b0);
        check("lane_merge", read_data, 32'hAA22CC44);
        access("wr_be0", 1'b0, 1'b1, 32'd1024, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0);
        access("rd_be0", 1'b1, 1'b0, 32'd1024, 32'd0, 4'hF, 1'b0, 1'b0);

        access("ill_below", 1'b1, 1'b0, 32'd1022, 32'd0, 4'h0, 1'b1, 1'b0);
        access("ill_unalign", 1'b1, 1'b0, 32'd1026, 32'd0, 4'h0, 1'b1, 1'b0);
        access("ill_above", 1'b1, 1'b0, 32'd1280, 32'd0, 4'h0, 1'b1, 1'b0);
        access("ill_both", 1'b1, 1'b1, 32'd1024, 32'h0, 4'hF, 1'b1, 1'b0);
        access("rd_after_ill", 1'b1, 1'b0, 32'd1024, 32'd0, 4'h0, 1'b0, 1'b0);

        access("wr_last", 1'b0, 1'b1, 32'd1276, 32'h600DCAFE, 4'hF, 1'b0, 1'b0);
        access("rd_last", 1'b1, 1'b0, 32'd1276, 32'd0, 4'h0, 1'b0, 1'b0);

        access("wr_midchg", 1'b0, 1'b1, 32'd1032, 32'h5555AAAA, 4'hF, 1'b0, 1'b1);
        access("rd_midchg", 1'b1, 1'b0, 32'd1032, 32'd0, 4'h0, 1'b0, 1'b0);
        access("rd_untouched", 1'b1, 1'b0, 32'd1036, 32'd0, 4'h0, 1'b0, 1'b0);

        // Reset arrives in the last BUSY cycle, one edge before the write would land.
        mem_write = 1'b1; addr = 32'd1028; write_data = 32'hDEADBEEF; byte_en = 4'hF;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("rstmid_ready", {31'd0, ready}, 32'd0);
        check("rstmid_rdata", read_data, 32'd0);
        @(negedge clk);
        mem_write = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rstmid_quiet", {31'd0, ready}, 32'd0);
        end
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        last_rd = '0;
        access("rd_after_rst", 1'b1, 1'b0, 32'd1028, 32'd0, 4'h0, 1'b0, 1'b0);
        access("rd_cleared", 1'b1, 1'b0, 32'd1024, 32'd0, 4'h0, 1'b0, 1'b0);

        // Zero-wait instance with the request held continuously, alternating write/read.
        begin
            int cyc;
            int last_cyc;
            int waited;
            logic [31:0] val;
            cyc = 0;
            last_cyc = -1;
            for (int k = 0; k < 6; k++) begin
                val = 32'hC0DE0000 + 32'(k / 2) * 32'h01010101;
                w0  = (k % 2 == 0);
                r0  = (k % 2 == 1);
                a0  = 32'd1040 + 32'(4 * (k / 2));
                wd0 = val;
                be0 = 4'hF;
                waited = 0;
                while (waited < 10) begin
                    @(posedge clk); #1;
                    cyc++;
                    waited++;
                    if (rdy0) break;
                end
                if (k == 0) check("z_first_latency", cyc, 2);
                else        check("z_interval", cyc - last_cyc, 3);
                last_cyc = cyc;
                check("z_err", {31'd0, err0}, 32'd0);
                if (k % 2 == 1) check("z_rdata", rd0, val);
            end
            r0 = 1'b0; w0 = 1'b0;
            @(posedge clk); #1;
            check("z_pulse", {31'd0, rdy0}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
